// File: rtl/piso_shift_tx_bidir.sv
// Parallel-in / serial-out transmitter with per-word bit-order selection (direccion).
// Optional macro PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_shift_tx_bidir #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [0:WIDTH-1] data_in_i,
  input  logic             direccion_i,
  output logic             sdo_o,
  output logic             sdo_valid_o,
  output logic             busy_o,
  output logic             done_o
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [0:WIDTH-1] shift_q, shift_d;
  logic             dir_q, dir_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;
  logic             accept;
  logic             bit_out;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign last_bit = (state_q == SHIFT) && (cnt_q == CW'(FRAME_LEN - 1));
  assign accept   = load_valid_i && load_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // An accept on the last-bit cycle reloads directly, so frames run back-to-back.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    if (accept) begin
      state_d  = SHIFT;
      shift_d  = data_in_i;
      dir_d    = direccion_i;
      cnt_d    = '0;
`ifdef PISO_PARITY_EN
      parity_d = ^data_in_i;
`endif
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (dir_q)
          shift_d = {1'b0, shift_q[0:WIDTH-2]};
        else
          shift_d = {shift_q[1:WIDTH-1], 1'b0};
      end
    end
  end

  // The parity bit follows the data bits regardless of shift direction.
  always_comb begin
    sdo_valid_o  = (state_q == SHIFT);
    busy_o       = (state_q == SHIFT);
    done_o       = last_bit;
    load_ready_o = (state_q == IDLE) || last_bit;
    bit_out      = dir_q ? shift_q[WIDTH-1] : shift_q[0];
`ifdef PISO_PARITY_EN
    if (cnt_q == CW'(WIDTH))
      bit_out = parity_q;
`endif
    sdo_o = sdo_valid_o ? bit_out : 1'b0;
  end

endmodule
